// File: rtl/ysyx_25040129_pkg.sv
// Shared definitions for the write-back unit: CSR map, reset constants, FSM encoding.
package ysyx_25040129_pkg;

    localparam int WBU_REGS_DIG = 4;
    localparam int WBU_CSR_DIG  = 12;

    localparam logic [WBU_CSR_DIG-1:0] CSR_MSTATUS  = 12'h300;
    localparam logic [WBU_CSR_DIG-1:0] CSR_MTVEC    = 12'h305;
    localparam logic [WBU_CSR_DIG-1:0] CSR_MSCRATCH = 12'h340;
    localparam logic [WBU_CSR_DIG-1:0] CSR_MEPC     = 12'h341;
    localparam logic [WBU_CSR_DIG-1:0] CSR_MCAUSE   = 12'h342;
    localparam logic [WBU_CSR_DIG-1:0] CSR_SATP     = 12'h180;

    localparam logic [31:0] MCAUSE_ECALL_M = 32'd11;
    localparam logic [31:0] MSTATUS_RESET  = 32'h0000_1800;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        REDIRECT = 2'd2
    } wbu_state_e;

    function automatic logic csr_is_implemented(input logic [WBU_CSR_DIG-1:0] addr);
        case (addr)
            CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH,
            CSR_MEPC, CSR_MCAUSE, CSR_SATP: csr_is_implemented = 1'b1;
            default:                        csr_is_implemented = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_25040129_wbu_if.sv
// LSU-to-WBU retire channel plus the WBU-to-fetch redirect channel.
interface ysyx_25040129_wbu_if #(
    parameter int REGS_DIG = ysyx_25040129_pkg::WBU_REGS_DIG,
    parameter int CSR_DIG  = ysyx_25040129_pkg::WBU_CSR_DIG
);
    logic                is_req_valid_from_lsu;
    logic                is_req_ready_to_lsu;
    logic [31:0]         pc_in_wbu;
    logic [31:0]         result_in_wbu;
    logic [31:0]         csrrw_csr_write_data_in_wbu;
    logic                reg_write_in_wbu;
    logic [REGS_DIG-1:0] rd_in_wbu;
    logic                csr_write_in_wbu;
    logic [CSR_DIG-1:0]  csr_addr_in_wbu;
    logic                ecall_in_wbu;
    logic                mret_in_wbu;
    logic                is_branch_in_wbu;
    logic                fence_i_in_wbu;
    logic [31:0]         branch_target_in_wbu;

    logic                redirect_valid;
    logic                redirect_ready;
    logic [31:0]         redirect_pc;
    logic                redirect_fence_i;

    // The master side is the surrounding pipeline (LSU + fetch), the slave side is the WBU.
    modport master (
        output is_req_valid_from_lsu, pc_in_wbu, result_in_wbu, csrrw_csr_write_data_in_wbu,
               reg_write_in_wbu, rd_in_wbu, csr_write_in_wbu, csr_addr_in_wbu,
               ecall_in_wbu, mret_in_wbu, is_branch_in_wbu, fence_i_in_wbu,
               branch_target_in_wbu, redirect_ready,
        input  is_req_ready_to_lsu, redirect_valid, redirect_pc, redirect_fence_i
    );

    modport slave (
        input  is_req_valid_from_lsu, pc_in_wbu, result_in_wbu, csrrw_csr_write_data_in_wbu,
               reg_write_in_wbu, rd_in_wbu, csr_write_in_wbu, csr_addr_in_wbu,
               ecall_in_wbu, mret_in_wbu, is_branch_in_wbu, fence_i_in_wbu,
               branch_target_in_wbu, redirect_ready,
        output is_req_ready_to_lsu, redirect_valid, redirect_pc, redirect_fence_i
    );

endinterface

// File: rtl/ysyx_25040129_regfile.sv
// General-purpose register file: two combinational read ports, one write port, x0 hardwired to zero.
module ysyx_25040129_regfile #(
    parameter int REGS_DIG = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [REGS_DIG-1:0] waddr,
    input  logic [31:0]         wdata,
    input  logic [REGS_DIG-1:0] raddr1,
    output logic [31:0]         rdata1,
    input  logic [REGS_DIG-1:0] raddr2,
    output logic [31:0]         rdata2
);

    localparam int NREGS = 1 << REGS_DIG;

    logic [31:0] regs [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? 32'd0 : regs[raddr1];
    assign rdata2 = (raddr2 == '0) ? 32'd0 : regs[raddr2];

endmodule

// File: rtl/ysyx_25040129_wbu.sv
// Write-back stage: commits GPR/CSR state, redirects fetch on ecall/mret/branch/fence.i.
// Optional commit trace ports and counter are enabled by YSYX_25040129_COMMIT_TRACE_EN.
module ysyx_25040129_wbu
    import ysyx_25040129_pkg::*;
#(
    parameter int REGS_DIG = WBU_REGS_DIG,
    parameter int CSR_DIG  = WBU_CSR_DIG
) (
    input  logic                clk,
    input  logic                rst,
    ysyx_25040129_wbu_if.slave  wbu,
    input  logic [REGS_DIG-1:0] rs1_addr,
    input  logic [REGS_DIG-1:0] rs2_addr,
    output logic [31:0]         rs1_data,
    output logic [31:0]         rs2_data,
    input  logic [CSR_DIG-1:0]  csr_raddr,
    output logic [31:0]         csr_rdata,
`ifdef YSYX_25040129_COMMIT_TRACE_EN
    input  logic [31:0]         inst_in_wbu,
    output logic [31:0]         pc_out_wbu,
    output logic [31:0]         inst_out_wbu,
    output logic [63:0]         commit_count,
`endif
    output logic                retire
);

    wbu_state_e state, state_next;

    logic [31:0]         pc_q, result_q, csr_wdata_q, target_q;
    logic                reg_write_q, csr_write_q, ecall_q, mret_q, branch_q, fence_i_q;
    logic [REGS_DIG-1:0] rd_q;
    logic [CSR_DIG-1:0]  csr_addr_q;
    logic [31:0]         redirect_pc_q;

    logic [31:0] mstatus, mtvec, mscratch, mepc, mcause, satp;

    logic        accept, committing, redirecting, csr_we;
    logic [31:0] redirect_target;

    assign accept      = (state == IDLE) && wbu.is_req_valid_from_lsu;
    assign committing  = (state == WRITE);
    assign redirecting = ecall_q || mret_q || branch_q || fence_i_q;
    assign csr_we      = committing && csr_write_q && csr_is_implemented(csr_addr_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next              = state;
        wbu.is_req_ready_to_lsu = 1'b0;
        wbu.redirect_valid      = 1'b0;
        retire                  = 1'b0;
        case (state)
            IDLE: begin
                wbu.is_req_ready_to_lsu = 1'b1;
                if (wbu.is_req_valid_from_lsu) state_next = WRITE;
            end
            WRITE: begin
                retire     = 1'b1;
                state_next = redirecting ? REDIRECT : IDLE;
            end
            REDIRECT: begin
                wbu.redirect_valid = 1'b1;
                if (wbu.redirect_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= '0;
            result_q    <= '0;
            csr_wdata_q <= '0;
            target_q    <= '0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            csr_write_q <= 1'b0;
            csr_addr_q  <= '0;
            ecall_q     <= 1'b0;
            mret_q      <= 1'b0;
            branch_q    <= 1'b0;
            fence_i_q   <= 1'b0;
        end else if (accept) begin
            pc_q        <= wbu.pc_in_wbu;
            result_q    <= wbu.result_in_wbu;
            csr_wdata_q <= wbu.csrrw_csr_write_data_in_wbu;
            target_q    <= wbu.branch_target_in_wbu;
            reg_write_q <= wbu.reg_write_in_wbu;
            rd_q        <= wbu.rd_in_wbu;
            csr_write_q <= wbu.csr_write_in_wbu;
            csr_addr_q  <= wbu.csr_addr_in_wbu;
            ecall_q     <= wbu.ecall_in_wbu;
            mret_q      <= wbu.mret_in_wbu;
            branch_q    <= wbu.is_branch_in_wbu;
            fence_i_q   <= wbu.fence_i_in_wbu;
        end
    end

    // Target uses the pre-commit mtvec/mepc, so it is captured at the same edge the CSRs commit.
    always_comb begin
        redirect_target = target_q;
        if (ecall_q)     redirect_target = mtvec;
        else if (mret_q) redirect_target = mepc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_pc_q <= '0;
        end else if (committing && redirecting) begin
            redirect_pc_q <= redirect_target;
        end
    end

    assign wbu.redirect_pc      = redirect_pc_q;
    assign wbu.redirect_fence_i = fence_i_q;

    // Trap bookkeeping is applied after the generic CSR write so ecall wins on mepc/mcause.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus  <= MSTATUS_RESET;
            mtvec    <= '0;
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
            satp     <= '0;
        end else if (committing) begin
            if (csr_we) begin
                case (csr_addr_q)
                    CSR_MSTATUS:  mstatus  <= csr_wdata_q;
                    CSR_MTVEC:    mtvec    <= csr_wdata_q;
                    CSR_MSCRATCH: mscratch <= csr_wdata_q;
                    CSR_MEPC:     mepc     <= csr_wdata_q;
                    CSR_MCAUSE:   mcause   <= csr_wdata_q;
                    CSR_SATP:     satp     <= csr_wdata_q;
                    default: ;
                endcase
            end
            if (ecall_q) begin
                mepc   <= pc_q;
                mcause <= MCAUSE_ECALL_M;
            end
        end
    end

    always_comb begin
        case (csr_raddr)
            CSR_MSTATUS:  csr_rdata = mstatus;
            CSR_MTVEC:    csr_rdata = mtvec;
            CSR_MSCRATCH: csr_rdata = mscratch;
            CSR_MEPC:     csr_rdata = mepc;
            CSR_MCAUSE:   csr_rdata = mcause;
            CSR_SATP:     csr_rdata = satp;
            default:      csr_rdata = 32'd0;
        endcase
    end

    ysyx_25040129_regfile #(
        .REGS_DIG (REGS_DIG)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (committing && reg_write_q),
        .waddr  (rd_q),
        .wdata  (result_q),
        .raddr1 (rs1_addr),
        .rdata1 (rs1_data),
        .raddr2 (rs2_addr),
        .rdata2 (rs2_data)
    );

`ifdef YSYX_25040129_COMMIT_TRACE_EN
    logic [31:0] inst_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_q       <= '0;
            commit_count <= '0;
        end else begin
            if (accept)     inst_q       <= inst_in_wbu;
            if (committing) commit_count <= commit_count + 64'd1;
        end
    end

    assign pc_out_wbu   = pc_q;
    assign inst_out_wbu = inst_q;
`endif

endmodule

// File: tb/tb_ysyx_25040129_wbu.sv
// Directed self-checking bench for ysyx_25040129_wbu: retire, x0, CSR writes, ecall/mret/fence.i redirects, reset.
module tb_ysyx_25040129_wbu;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ysyx_25040129_wbu_if bus ();

    logic [3:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        retire;

    int vec_count    = 0;
    int miscompares  = 0;
    int retire_total = 0;

`ifdef YSYX_25040129_COMMIT_TRACE_EN
    logic [31:0] inst_in_wbu, pc_out_wbu, inst_out_wbu;
    logic [63:0] commit_count;
`endif

    ysyx_25040129_wbu dut (
        .clk          (clk),
        .rst          (rst),
        .wbu          (bus.slave),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .csr_raddr    (csr_raddr),
        .csr_rdata    (csr_rdata),
`ifdef YSYX_25040129_COMMIT_TRACE_EN
        .inst_in_wbu  (inst_in_wbu),
        .pc_out_wbu   (pc_out_wbu),
        .inst_out_wbu (inst_out_wbu),
        .commit_count (commit_count),
`endif
        .retire       (retire)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vec_count++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic readCsr(input string tag, input logic [11:0] addr, input logic [31:0] expected);
        csr_raddr = addr;
        #1;
        checkOutput(tag, {32'd0, csr_rdata}, {32'd0, expected});
    endtask

    task automatic readGpr(input string tag, input logic [3:0] addr, input logic [31:0] expected);
        rs1_addr = addr;
        #1;
        checkOutput(tag, {32'd0, rs1_data}, {32'd0, expected});
    endtask

    // Presents one instruction in IDLE, lets it be accepted, and leaves the bench mid-WRITE.
    task automatic applyStimulus(
        input logic [31:0] pc, input logic [31:0] result,
        input logic reg_write, input logic [3:0] rd,
        input logic csr_write, input logic [11:0] caddr, input logic [31:0] cdata,
        input logic ecall, input logic mret, input logic branch, input logic fence_i,
        input logic [31:0] target
    );
        @(negedge clk);
        checkOutput("ready_before_accept", {63'd0, bus.is_req_ready_to_lsu}, 64'd1);
        bus.pc_in_wbu                   = pc;
        bus.result_in_wbu               = result;
        bus.reg_write_in_wbu            = reg_write;
        bus.rd_in_wbu                   = rd;
        bus.csr_write_in_wbu            = csr_write;
        bus.csr_addr_in_wbu             = caddr;
        bus.csrrw_csr_write_data_in_wbu = cdata;
        bus.ecall_in_wbu                = ecall;
        bus.mret_in_wbu                 = mret;
        bus.is_branch_in_wbu            = branch;
        bus.fence_i_in_wbu              = fence_i;
        bus.branch_target_in_wbu        = target;
        bus.is_req_valid_from_lsu       = 1'b1;
        @(posedge clk);
        #1;
        bus.is_req_valid_from_lsu = 1'b0;
        @(negedge clk);
        checkOutput("retire_in_write", {63'd0, retire}, 64'd1);
        checkOutput("ready_in_write", {63'd0, bus.is_req_ready_to_lsu}, 64'd0);
        retire_total++;
    endtask

    initial begin
        rst       = 1'b1;
        rs1_addr  = 4'd0;
        rs2_addr  = 4'd0;
        csr_raddr = 12'h000;
        bus.is_req_valid_from_lsu       = 1'b0;
        bus.pc_in_wbu                   = '0;
        bus.result_in_wbu               = '0;
        bus.csrrw_csr_write_data_in_wbu = '0;
        bus.reg_write_in_wbu            = 1'b0;
        bus.rd_in_wbu                   = '0;
        bus.csr_write_in_wbu            = 1'b0;
        bus.csr_addr_in_wbu             = '0;
        bus.ecall_in_wbu                = 1'b0;
        bus.mret_in_wbu                 = 1'b0;
        bus.is_branch_in_wbu            = 1'b0;
        bus.fence_i_in_wbu              = 1'b0;
        bus.branch_target_in_wbu        = '0;
        bus.redirect_ready              = 1'b0;
`ifdef YSYX_25040129_COMMIT_TRACE_EN
        inst_in_wbu = 32'h0000_0013;
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_ready", {63'd0, bus.is_req_ready_to_lsu}, 64'd1);
        checkOutput("rst_redirect_valid", {63'd0, bus.redirect_valid}, 64'd0);
        checkOutput("rst_redirect_pc", {32'd0, bus.redirect_pc}, 64'd0);
        checkOutput("rst_redirect_fence_i", {63'd0, bus.redirect_fence_i}, 64'd0);
        checkOutput("rst_retire", {63'd0, retire}, 64'd0);
        readCsr("rst_mstatus", 12'h300, 32'h0000_1800);
        readGpr("rst_x5", 4'd5, 32'd0);

        // add x5
        rs1_addr = 4'd5;
        applyStimulus(32'h8000_0000, 32'h1234_5678, 1'b1, 4'd5, 1'b0, 12'h000, 32'd0,
                      1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("x5_no_bypass", {32'd0, rs1_data}, 64'd0);
        stepCycle();
        checkOutput("add_retire_low", {63'd0, retire}, 64'd0);
        checkOutput("add_x5", {32'd0, rs1_data}, 64'h1234_5678);
        checkOutput("add_no_redirect", {63'd0, bus.redirect_valid}, 64'd0);

        // write to x0 is dropped
        applyStimulus(32'h8000_0004, 32'hFFFF_FFFF, 1'b1, 4'd0, 1'b0, 12'h000, 32'd0,
                      1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        stepCycle();
        rs2_addr = 4'd0;
        #1;
        checkOutput("x0_zero", {32'd0, rs2_data}, 64'd0);
        readGpr("x5_kept", 4'd5, 32'h1234_5678);

        // csrrw mtvec, mstatus, and an unimplemented CSR
        applyStimulus(32'h8000_0008, 32'd0, 1'b1, 4'd6, 1'b1, 12'h305, 32'h8000_0100,
                      1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        stepCycle();
        readCsr("mtvec_write", 12'h305, 32'h8000_0100);
        applyStimulus(32'h8000_000C, 32'h0000_1800, 1'b0, 4'd0, 1'b1, 12'h300, 32'd0,
                      1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        stepCycle();
        readCsr("mstatus_write", 12'h300, 32'd0);
        applyStimulus(32'h8000_0010, 32'd0, 1'b0, 4'd0, 1'b1, 12'h7C0, 32'hDEAD_BEEF,
                      1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        stepCycle();
        readCsr("unimpl_csr", 12'h7C0, 32'd0);

        // ecall that also tries to write mcause: trap values win
        applyStimulus(32'h8000_0040, 32'd0, 1'b0, 4'd0, 1'b1, 12'h342, 32'h0000_0055,
                      1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        stepCycle();
        checkOutput("ecall_redirect_valid", {63'd0, bus.redirect_valid}, 64'd1);
        checkOutput("ecall_redirect_pc", {32'd0, bus.redirect_pc}, 64'h8000_0100);
        checkOutput("ecall_fence_i", {63'd0, bus.redirect_fence_i}, 64'd0);
        readCsr("ecall_mepc", 12'h341, 32'h8000_0040);
        readCsr("ecall_mcause", 12'h342, 32'd11);
        bus.redirect_ready = 1'b1;
        stepCycle();
        bus.redirect_ready = 1'b0;
        checkOutput("ecall_handshake_idle", {63'd0, bus.is_req_ready_to_lsu}, 64'd1);
        checkOutput("ecall_redirect_drop", {63'd0, bus.redirect_valid}, 64'd0);

        // mret with redirect_ready held low for three cycles
        applyStimulus(32'h8000_0100, 32'd0, 1'b0, 4'd0, 1'b0, 12'h000, 32'd0,
                      1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput("mret_hold_valid", {63'd0, bus.redirect_valid}, 64'd1);
            checkOutput("mret_hold_pc", {32'd0, bus.redirect_pc}, 64'h8000_0040);
            checkOutput("mret_hold_lsu_ready", {63'd0, bus.is_req_ready_to_lsu}, 64'd0);
        end
        bus.redirect_ready = 1'b1;
        stepCycle();
        bus.redirect_ready = 1'b0;
        checkOutput("mret_handshake_idle", {63'd0, bus.is_req_ready_to_lsu}, 64'd1);

        // fence.i with redirect_ready pre-asserted: one REDIRECT cycle
        bus.redirect_ready = 1'b1;
        applyStimulus(32'h8000_0040, 32'd0, 1'b0, 4'd0, 1'b0, 12'h000, 32'd0,
                      1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0044);
        stepCycle();
        checkOutput("fence_redirect_valid", {63'd0, bus.redirect_valid}, 64'd1);
        checkOutput("fence_redirect_fence_i", {63'd0, bus.redirect_fence_i}, 64'd1);
        checkOutput("fence_redirect_pc", {32'd0, bus.redirect_pc}, 64'h8000_0044);
        stepCycle();
        bus.redirect_ready = 1'b0;
        checkOutput("fence_back_idle", {63'd0, bus.is_req_ready_to_lsu}, 64'd1);
        checkOutput("fence_redirect_drop", {63'd0, bus.redirect_valid}, 64'd0);

        // taken branch writing x7, then reset while in REDIRECT
        applyStimulus(32'h8000_0044, 32'h0000_ABCD, 1'b1, 4'd7, 1'b0, 12'h000, 32'd0,
                      1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0200);
        stepCycle();
        checkOutput("branch_redirect_valid", {63'd0, bus.redirect_valid}, 64'd1);
        checkOutput("branch_redirect_pc", {32'd0, bus.redirect_pc}, 64'h8000_0200);
        readGpr("branch_x7", 4'd7, 32'h0000_ABCD);
`ifdef YSYX_25040129_COMMIT_TRACE_EN
        checkOutput("commit_count", commit_count, 64'(retire_total));
`endif
        rst = 1'b1;
        #1;
        checkOutput("midrst_redirect_valid", {63'd0, bus.redirect_valid}, 64'd0);
        checkOutput("midrst_ready", {63'd0, bus.is_req_ready_to_lsu}, 64'd1);
        checkOutput("midrst_redirect_pc", {32'd0, bus.redirect_pc}, 64'd0);
        readCsr("midrst_mstatus", 12'h300, 32'h0000_1800);
        readCsr("midrst_mtvec", 12'h305, 32'd0);
        readGpr("midrst_x5", 4'd5, 32'd0);
        readGpr("midrst_x7", 4'd7, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        stepCycle();
        checkOutput("post_rst_idle", {63'd0, bus.is_req_ready_to_lsu}, 64'd1);
        checkOutput("post_rst_retire", {63'd0, retire}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
